pose_input_ctrl: RTL

POSE_INPUT_CTRL -- requirements
Module: pose_input_ctrl

---
 rtl/pose_input_ctrl.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/pose_input_ctrl.sv
// pose_input_ctrl: button front end plus frame-stable pose register.
//
// Buttons: each raw level goes through a 2-flop synchronizer and a debouncer.
// Clean rising edges (and, optionally, auto-repeats while the button is held)
// raise a per-channel pending bit. Pending bits are drained one at a time
// through a valid/ready command port, lowest channel index first. An event
// that lands on an already-pending channel is dropped and counted.
//
// Pose: poses from the movement engine land in a shadow register. They are
// published to pose_out only at a frame boundary, so a frame never sees a
// torn or mid-frame pose.
//
// Configuration macro: POSE_INPUT_REPEAT_EN enables auto-repeat. Without it
// there are no repeat timers and cmd_repeat_out is tied to 0.
//
// Ports:
//   clk_in, rst_in      clock, synchronous active-low reset
//   btn_in              raw asynchronous button levels
//   cmd_valid_out/cmd_ready_in/cmd_id_out/cmd_repeat_out   command handshake
//   pose_valid_in, pose_in   new pose from movement engine (posX in LSBs)
//   frame_switch        frame boundary strobe
//   pose_out, pose_update_out   published pose and its change pulse
//   drop_count_out      saturating count of dropped events

// Per-channel synchronizer, debouncer and (optional) repeat timer.
module pose_btn_chan #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
`ifdef POSE_INPUT_REPEAT_EN
    output logic ev_rpt,
`endif
    output logic ev
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic            sync1, sync2, clean;
    logic [DB_W-1:0] db_cnt;
    logic            flip;

    // db_cnt counts consecutive disagreeing samples; the last one flips clean.
    assign flip = (sync2 != clean) && (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            clean  <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == clean) begin
                db_cnt <= '0;
            end else if (flip) begin
                clean  <= ~clean;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

`ifdef POSE_INPUT_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_tmr;
    logic             first;   // still waiting for the initial (longer) delay
    logic             rpt_hit;

    assign rpt_hit = clean && (first ? (rpt_tmr == RPT_W'(REPEAT_DELAY - 1))
                                     : (rpt_tmr == RPT_W'(REPEAT_PERIOD - 1)));

    // Any clean edge restarts the timer; it only runs while clean is high.
    always_ff @(posedge clk) begin
        if (!rst_n || flip) begin
            rpt_tmr <= '0;
            first   <= 1'b1;
        end else if (rpt_hit) begin
            rpt_tmr <= '0;
            first   <= 1'b0;
        end else if (clean) begin
            rpt_tmr <= rpt_tmr + RPT_W'(1);
        end
    end

    assign ev_rpt = rpt_hit;
    assign ev     = (flip && !clean) || rpt_hit;
`else
    assign ev     = flip && !clean;
`endif
endmodule

module pose_input_ctrl #(
    parameter int NUM_BTNS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000,
    parameter int POSE_W          = 16,
    parameter logic [6*POSE_W-1:0] INIT_POSE = '0,
    localparam int ID_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic                cmd_valid_out,
    input  logic                cmd_ready_in,
    output logic [ID_W-1:0]     cmd_id_out,
    output logic                cmd_repeat_out,
    input  logic                pose_valid_in,
    input  logic [6*POSE_W-1:0] pose_in,
    input  logic                frame_switch,
    output logic [6*POSE_W-1:0] pose_out,
    output logic                pose_update_out,
    output logic [15:0]         drop_count_out
);
    localparam int CNT_W = $clog2(NUM_BTNS + 1);

    logic [NUM_BTNS-1:0] ev, pend, hit_acc, drop_ev;
    logic                accept;
    logic [ID_W-1:0]     next_id;
    logic [CNT_W-1:0]    n_drop;
    logic [16:0]         drop_sum;
`ifdef POSE_INPUT_REPEAT_EN
    logic [NUM_BTNS-1:0] ev_rpt, pend_rpt, load;
`endif

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        pose_btn_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk    (clk_in),
            .rst_n  (rst_in),
            .raw    (btn_in[i]),
`ifdef POSE_INPUT_REPEAT_EN
            .ev_rpt (ev_rpt[i]),
`endif
            .ev     (ev[i])
        );
    end

    assign accept = cmd_valid_out && cmd_ready_in;

    always_comb begin
        next_id = '0;
        hit_acc = '0;
        n_drop  = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (pend[i]) next_id = ID_W'(i);
        end
        for (int i = 0; i < NUM_BTNS; i++) begin
            hit_acc[i] = accept && (cmd_id_out == ID_W'(i));
        end
        // The channel being accepted frees its slot this edge, so its new
        // event is not a drop.
        drop_ev = ev & pend & ~hit_acc;
        for (int i = 0; i < NUM_BTNS; i++) begin
            n_drop = n_drop + CNT_W'(drop_ev[i]);
        end
    end

    assign drop_sum = {1'b0, drop_count_out} + 17'(n_drop);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pend           <= '0;
            cmd_valid_out  <= 1'b0;
            cmd_id_out     <= '0;
            drop_count_out <= '0;
        end else begin
            pend           <= (pend & ~hit_acc) | ev;
            drop_count_out <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            // Valid drops after every accept, giving the mandatory idle cycle.
            if (accept) begin
                cmd_valid_out <= 1'b0;
            end else if (!cmd_valid_out && |pend) begin
                cmd_valid_out <= 1'b1;
                cmd_id_out    <= next_id;
            end
        end
    end

`ifdef POSE_INPUT_REPEAT_EN
    // Repeat flag is captured only for events that actually (re)fill a slot.
    assign load = ev & ~(pend & ~hit_acc);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            pend_rpt       <= '0;
            cmd_repeat_out <= 1'b0;
        end else begin
            pend_rpt <= (pend_rpt & ~load) | (ev_rpt & load);
            if (!accept && !cmd_valid_out && |pend) cmd_repeat_out <= pend_rpt[next_id];
        end
    end
`else
    assign cmd_repeat_out = 1'b0;
`endif

    logic [6*POSE_W-1:0] shadow;
    logic                dirty;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            shadow          <= INIT_POSE;
            pose_out        <= INIT_POSE;
            dirty           <= 1'b0;
            pose_update_out <= 1'b0;
        end else begin
            pose_update_out <= 1'b0;
            if (pose_valid_in && frame_switch) begin
                // Pose arriving on the boundary goes straight out.
                pose_out        <= pose_in;
                shadow          <= pose_in;
                dirty           <= 1'b0;
                pose_update_out <= 1'b1;
            end else begin
                if (pose_valid_in) begin
                    shadow <= pose_in;
                    dirty  <= 1'b1;
                end
                if (frame_switch && dirty) begin
                    pose_out        <= shadow;
                    dirty           <= 1'b0;
                    pose_update_out <= 1'b1;
                end
            end
        end
    end
endmodule
